ifetch_ctrl: RTL and testbench

//   Instruction-fetch controller for the single-cycle-read instruction memory (byte PC, word array).

---
 rtl/ifetch_pkg.sv | 13 +
 rtl/ifetch_ctrl_fifo.sv | 73 +++++++
 rtl/ifetch_ctrl.sv | 91 +++++++++
 tb/tb_ifetch_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction-fetch controller: FSM encoding and PC constants.
package ifetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam int          PC_STEP    = 4;
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/ifetch_ctrl_fifo.sv
// Fetch buffer: small synchronous FIFO of {pc,instr} entries with flush.
// The head output holds its last shown value while the buffer is empty.
module fetch_fifo #(
  parameter int DATA_W = 40,
  parameter int DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [DATA_W-1:0]      push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [DATA_W-1:0]      head_data,
  output logic                   not_empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [DATA_W-1:0] hold_data;
  logic              full;
  logic              do_push;
  logic              do_pop;

  assign not_empty = (count != '0);
  assign full      = (count == CW'(DEPTH));
  assign do_pop    = pop & not_empty;
  // A push into a full buffer is only legal when the head leaves the same cycle.
  assign do_push   = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      hold_data <= '0;
    end else begin
      if (not_empty) begin
        hold_data <= head_data;
      end
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (do_pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        case ({do_push, do_pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  assign head_data = not_empty ? mem[rd_ptr] : hold_data;

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: PC register, fetch FSM and redirect handling,
// feeding IMEM words into a fetch buffer that decode drains via valid/ready.
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter int                  PC_WIDTH    = 8,
  parameter int                  INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter int                  FIFO_DEPTH  = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        fetch_en,
  input  logic                        redirect_valid,
  input  logic [PC_WIDTH-1:0]         redirect_pc,
  output logic [PC_WIDTH-1:0]         imem_pc,
  input  logic [INSTR_WIDTH-1:0]      imem_instr,
  output logic                        if_valid,
  input  logic                        if_ready,
  output logic [INSTR_WIDTH-1:0]      if_instr,
  output logic [PC_WIDTH-1:0]         if_pc,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = PC_WIDTH + INSTR_WIDTH;

  state_e              state;
  state_e              state_nxt;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] pc_nxt;
  logic                enq;
  logic                deq;
  logic [EW-1:0]       head;

  assign deq = if_valid & if_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    enq       = 1'b0;
    pc_nxt    = pc;
    if (redirect_valid) begin
      state_nxt = FLUSH;
    end else begin
      case (state)
        IDLE:    state_nxt = fetch_en ? FETCH : IDLE;
        FETCH:   state_nxt = fetch_en ? FETCH : IDLE;
        FLUSH:   state_nxt = fetch_en ? FETCH : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
    // Fetch only while a slot is free or the head is leaving this cycle.
    enq = (state == FETCH) && !redirect_valid &&
          ((fifo_count < CW'(FIFO_DEPTH)) || deq);
    if (redirect_valid) begin
      pc_nxt = redirect_pc & PC_WIDTH'(ALIGN_MASK);
    end else if (enq) begin
      pc_nxt = pc + PC_WIDTH'(PC_STEP);
    end
  end

  fetch_fifo #(
    .DATA_W (EW),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (enq),
    .push_data ({pc, imem_instr}),
    .pop       (deq),
    .flush     (redirect_valid),
    .head_data (head),
    .not_empty (if_valid),
    .count     (fifo_count)
  );

  assign imem_pc  = pc;
  assign if_pc    = head[EW-1 -: PC_WIDTH];
  assign if_instr = head[INSTR_WIDTH-1:0];

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl with a combinational IMEM model (word i = 0xCAFE0000 + i).
module tb_ifetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_pc = 8'h00;
  logic [7:0]  imem_pc;
  logic [31:0] imem_instr;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [7:0]  if_pc;
  logic [1:0]  fifo_count;

  logic [31:0] imem [64];
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  assign imem_instr = imem[imem_pc[7:2]];

  ifetch_ctrl #(
    .PC_WIDTH    (8),
    .INSTR_WIDTH (32),
    .RESET_PC    (8'h00),
    .FIFO_DEPTH  (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_pc        (imem_pc),
    .imem_instr     (imem_instr),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .fifo_count     (fifo_count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) imem[i] = 32'hCAFE_0000 + i;

    // Reset state
    step(2);
    chk("rst_imem_pc", imem_pc, 8'h00);
    chk("rst_valid", if_valid, 1'b0);
    chk("rst_count", fifo_count, 2'd0);
    chk("rst_if_pc", if_pc, 8'h00);
    chk("rst_if_instr", if_instr, 32'h0);

    // Streaming fetch with decode always ready
    rst_n = 1'b1; fetch_en = 1'b1; if_ready = 1'b1;
    step(1);
    chk("t1_not_yet_valid", if_valid, 1'b0);
    step(1);
    chk("t1_valid0", if_valid, 1'b1);
    chk("t1_pc0", if_pc, 8'h00);
    chk("t1_instr0", if_instr, 32'hCAFE_0000);
    step(1);
    chk("t1_pc1", if_pc, 8'h04);
    chk("t1_instr1", if_instr, 32'hCAFE_0001);
    step(1);
    chk("t1_pc2", if_pc, 8'h08);
    chk("t1_instr2", if_instr, 32'hCAFE_0002);

    // Backpressure from a fresh start
    rst_n = 1'b0; if_ready = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(5);
    chk("t2_count_sat", fifo_count, 2'd2);
    chk("t2_pc_stall", imem_pc, 8'h08);
    chk("t2_head_pc", if_pc, 8'h00);
    chk("t2_head_instr", if_instr, 32'hCAFE_0000);
    if_ready = 1'b1;
    step(1);
    chk("t2_resume_pc4", if_pc, 8'h04);
    chk("t2_count_full", fifo_count, 2'd2);
    chk("t2_imem_pc", imem_pc, 8'h0C);
    step(1);
    chk("t2_pc8", if_pc, 8'h08);
    chk("t2_instr8", if_instr, 32'hCAFE_0002);
    step(1);
    chk("t2_pcC", if_pc, 8'h0C);

    // Redirect with two words buffered; target low bits dropped
    chk("t3_pre_count", fifo_count, 2'd2);
    redirect_valid = 1'b1; redirect_pc = 8'h43;
    step(1);
    redirect_valid = 1'b0;
    chk("t3_count_flush", fifo_count, 2'd0);
    chk("t3_valid_flush", if_valid, 1'b0);
    chk("t3_imem_pc", imem_pc, 8'h40);
    chk("t3_if_pc_hold", if_pc, 8'h0C);
    step(1);
    chk("t3_flush_no_enq", if_valid, 1'b0);
    step(1);
    chk("t3_if_pc", if_pc, 8'h40);
    chk("t3_if_instr", if_instr, 32'hCAFE_0010);

    // PC wrap past the top of the address space
    redirect_valid = 1'b1; redirect_pc = 8'hF8;
    step(1);
    redirect_valid = 1'b0;
    step(2);
    chk("t4_pcF8", if_pc, 8'hF8);
    step(1);
    chk("t4_pcFC", if_pc, 8'hFC);
    chk("t4_imem_wrap", imem_pc, 8'h00);
    step(1);
    chk("t4_pc00", if_pc, 8'h00);
    chk("t4_instr00", if_instr, 32'hCAFE_0000);
    step(1);
    chk("t4_pc04", if_pc, 8'h04);

    // Stop fetching with a full buffer, then drain
    if_ready = 1'b0;
    step(2);
    fetch_en = 1'b0;
    step(1);
    chk("t5_count_full", fifo_count, 2'd2);
    chk("t5_imem_pc", imem_pc, 8'h0C);
    if_ready = 1'b1;
    step(1);
    chk("t5_drain_pc", if_pc, 8'h08);
    chk("t5_count1", fifo_count, 2'd1);
    chk("t5_frozen1", imem_pc, 8'h0C);
    step(1);
    chk("t5_empty_valid", if_valid, 1'b0);
    chk("t5_count0", fifo_count, 2'd0);
    chk("t5_frozen2", imem_pc, 8'h0C);
    chk("t5_if_pc_hold", if_pc, 8'h08);

    // Asynchronous reset between clock edges
    fetch_en = 1'b1;
    step(3);
    chk("t6_pre_valid", if_valid, 1'b1);
    chk("t6_pre_pc", if_pc, 8'h10);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", if_valid, 1'b0);
    chk("t6_async_count", fifo_count, 2'd0);
    chk("t6_async_imem_pc", imem_pc, 8'h00);
    chk("t6_async_if_pc", if_pc, 8'h00);
    chk("t6_async_instr", if_instr, 32'h0);
    step(1);
    rst_n = 1'b1;
    step(1);
    chk("t6_post_not_valid", if_valid, 1'b0);
    step(1);
    chk("t6_post_valid", if_valid, 1'b1);
    chk("t6_post_pc", if_pc, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
